caravel_clock_monitor: RTL and testbench
========================================

Name: caravel_clock_monitor

Overview:
Frequency monitor for the clocks generated by the clock block. It takes a monitored clock or divided-clock signal (mon_in) that is asynchronous to clk. It counts rising edges of mon_in over a programmable window of clk cycles and reports the count with a one-cycle valid strobe. Each count is compared against programmable limits, and out-of-range results raise a sticky fault for housekeeping.

Parameters:
WINDOW_BITS, 16, width of the window length field; window = window_len+1 clk cycles
COUNT_BITS, 12, width of the edge counter and of the limit fields

Ports:
clk  input  1  monitor clock; all state in this domain
resetb  input  1  asynchronous active-low reset
enable  input  1  1 = measure continuously, 0 = idle
mon_in  input  1  monitored signal, asynchronous to clk; toggle rate must be < clk/2
window_len  input  WINDOW_BITS  window length minus one, in clk cycles
lo_limit  input  COUNT_BITS  minimum acceptable edge count
hi_limit  input  COUNT_BITS  maximum acceptable edge count
fault_clear  input  1  synchronous clear of fault_sticky
count  output  COUNT_BITS  edge count of the last completed window
valid  output  1  one-cycle pulse when count and flags update
too_slow  output  1  last count < lo_limit
too_fast  output  1  last count > hi_limit
overflow  output  1  last window's edge counter saturated
fault_sticky  output  1  set on any too_slow/too_fast result; held until fault_clear
busy  output  1  high in SETTLE and MEASURE

Behaviour:
- Reset (resetb=0, async): state=IDLE; sync flops, edge counter and window counter cleared; count=0; valid, too_slow, too_fast, overflow, fault_sticky and busy all 0.
- Synchronizer: mon_in passes through 2 flops (s1, s2) plus a history flop s3. Rising edge detected when s2 & ~s3. Edge-to-detect latency is 3 clk cycles.
- FSM states: IDLE, SETTLE, MEASURE.
- IDLE: if enable=1, go to SETTLE next cycle.
- SETTLE: lasts exactly 3 cycles so the synchronizer is flushed; edges are ignored.
  - At SETTLE entry, window_len is loaded into the window counter wcnt.
  - After the 3 cycles, go to MEASURE with edge_cnt=0.
- MEASURE: each cycle, edge_cnt increments on a detected edge, saturating at 2^COUNT_BITS-1. wcnt decrements by 1.
- Last MEASURE cycle (wcnt==0):
  - Result = edge_cnt + edge_this_cycle, saturated at 2^COUNT_BITS-1.
  - Next cycle: count=result, valid=1 for one cycle.
  - too_slow = (result < lo_limit) and too_fast = (result > hi_limit), using limits sampled on the last MEASURE cycle.
  - overflow = 1 if saturation occurred at any point in the window.
  - In the same transition edge_cnt restarts at 0 and wcnt reloads window_len, so windows run back-to-back with no gap.
- window_len is sampled only at reload. Changing it mid-window has no effect until the next window.
- window_len=0 gives a 1-cycle window.
- enable=0 in any state: go to IDLE next cycle.
  - A partial window is discarded with no valid pulse.
  - count and flags hold their last values.
  - Re-enable always passes through SETTLE again.
- fault_sticky is set on the valid cycle if too_slow|too_fast. fault_clear=1 clears it.
  - If clear and set coincide, set wins.
- Limits are unsigned. If lo_limit > hi_limit, every result is flagged.
- Reset mid-window aborts immediately; all outputs return to their reset values.

Test Plan:
- window_len=99, mon_in period 10 clk, lo=9, hi=11, enable=1 -> first valid 3+100 cycles after SETTLE entry. count=10, too_slow=0, too_fast=0, fault_sticky=0. valid repeats every 100 cycles.
- Same setup, mon_in period 20 -> count=5, too_slow=1, fault_sticky=1. Period back to 10 -> count=10 and flags clear, but fault_sticky stays 1 until a fault_clear pulse.
- window_len=9999, mon_in period 2, hi=4000 -> count=4095, overflow=1, too_fast=1.
- Drop enable at cycle 50 of a window -> no valid, count holds its previous value, busy=0. Re-enable -> 3 SETTLE cycles, then a fresh full window.
- Change window_len 99->49 mid-window -> current window still 100 cycles, the next window 50 cycles (count=5 at period 10).
- Assert resetb=0 mid-window -> all outputs 0 asynchronously. After release with enable=1 -> normal measurement resumes via SETTLE.

Source files
------------

// File: rtl/caravel_clock_monitor.sv
// Frequency monitor: counts synchronized rising edges of mon_in over a
// programmable window of clk cycles and range-checks each result.
module caravel_clock_monitor #(
  parameter int WINDOW_BITS = 16,
  parameter int COUNT_BITS  = 12
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   enable,
  input  logic                   mon_in,
  input  logic [WINDOW_BITS-1:0] window_len,
  input  logic [COUNT_BITS-1:0]  lo_limit,
  input  logic [COUNT_BITS-1:0]  hi_limit,
  input  logic                   fault_clear,
  output logic [COUNT_BITS-1:0]  count,
  output logic                   valid,
  output logic                   too_slow,
  output logic                   too_fast,
  output logic                   overflow,
  output logic                   fault_sticky,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} state_t;

  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

  state_t                 state_q;
  logic                   s1_q, s2_q, s3_q;
  logic [1:0]             settle_q;
  logic [WINDOW_BITS-1:0] wcnt_q;
  logic [COUNT_BITS-1:0]  ecnt_q;
  logic                   sat_q;
  logic [COUNT_BITS-1:0]  count_q;
  logic                   valid_q, slow_q, fast_q, ovf_q, fault_q, busy_q;

  logic                   edge_det;
  logic                   clip_d;
  logic [COUNT_BITS-1:0]  result_d;
  logic                   slow_d, fast_d;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v,
                                                    input logic inc);
    if (inc && (v != CNT_MAX)) sat_inc = v + COUNT_BITS'(1);
    else                       sat_inc = v;
  endfunction

  always_comb begin
    edge_det = s2_q & ~s3_q;
    clip_d   = edge_det & (ecnt_q == CNT_MAX);
    result_d = sat_inc(ecnt_q, edge_det);
    slow_d   = (result_d < lo_limit);
    fast_d   = (result_d > hi_limit);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      settle_q <= 2'd0;
      wcnt_q   <= '0;
      ecnt_q   <= '0;
      sat_q    <= 1'b0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      slow_q   <= 1'b0;
      fast_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      s1_q    <= mon_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      valid_q <= 1'b0;
      if (fault_clear) fault_q <= 1'b0;

      if (!enable) begin
        // Any partial window is dropped; published results are left untouched.
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q  <= SETTLE;
            busy_q   <= 1'b1;
            settle_q <= 2'd0;
            wcnt_q   <= window_len;
          end
          SETTLE: begin
            if (settle_q == 2'd2) begin
              state_q <= MEASURE;
              ecnt_q  <= '0;
              sat_q   <= 1'b0;
            end else begin
              settle_q <= settle_q + 2'd1;
            end
          end
          MEASURE: begin
            if (wcnt_q == '0) begin
              // Publish and immediately start the next window with no gap.
              count_q <= result_d;
              valid_q <= 1'b1;
              slow_q  <= slow_d;
              fast_q  <= fast_d;
              ovf_q   <= sat_q | clip_d;
              if (slow_d | fast_d) fault_q <= 1'b1;
              ecnt_q  <= '0;
              sat_q   <= 1'b0;
              wcnt_q  <= window_len;
            end else begin
              ecnt_q <= result_d;
              sat_q  <= sat_q | clip_d;
              wcnt_q <= wcnt_q - WINDOW_BITS'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count        = count_q;
  assign valid        = valid_q;
  assign too_slow     = slow_q;
  assign too_fast     = fast_q;
  assign overflow     = ovf_q;
  assign fault_sticky = fault_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_caravel_clock_monitor.sv
// Scoreboard bench for caravel_clock_monitor: expected window results are
// queued as stimulus is set up and compared on each valid pulse.
module tb_caravel_clock_monitor;

  logic        clk;
  logic        resetb;
  logic        enable;
  logic        mon_in;
  logic [15:0] window_len;
  logic [11:0] lo_limit;
  logic [11:0] hi_limit;
  logic        fault_clear;
  logic [11:0] count;
  logic        valid;
  logic        too_slow;
  logic        too_fast;
  logic        overflow;
  logic        fault_sticky;
  logic        busy;

  caravel_clock_monitor #(.WINDOW_BITS(16), .COUNT_BITS(12)) dut (
    .clk          (clk),
    .resetb       (resetb),
    .enable       (enable),
    .mon_in       (mon_in),
    .window_len   (window_len),
    .lo_limit     (lo_limit),
    .hi_limit     (hi_limit),
    .fault_clear  (fault_clear),
    .count        (count),
    .valid        (valid),
    .too_slow     (too_slow),
    .too_fast     (too_fast),
    .overflow     (overflow),
    .fault_sticky (fault_sticky),
    .busy         (busy)
  );

  typedef struct {
    bit chk;
    int cnt;
    bit slow;
    bit fast;
    bit ovf;
    bit flt;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   per   = 10;
  int   ph    = 0;
  int   t0    = 0;
  int   last_v = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic push(input bit c, input int cnt, input bit slow, input bit fast,
                      input bit ovf, input bit flt, input int gap);
    exp_t e;
    e.chk = c; e.cnt = cnt; e.slow = slow; e.fast = fast;
    e.ovf = ovf; e.flt = flt; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic start_en();
    @(posedge clk);
    #1;
    enable = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_first(input string tag);
    int n = 0;
    @(negedge clk);
    while (!valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, cyc - t0, 104);
  endtask

  task automatic chk_reset_outs();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_slow", 32'(too_slow), 0);
    chk("rst_fast", 32'(too_fast), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_fault", 32'(fault_sticky), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  // Monitored signal: rising edge once every per clk cycles.
  initial begin
    mon_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph = ph + 1;
      if (ph >= per) ph = 0;
      mon_in = (ph < per / 2);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetb && valid) begin
        if (sb.size() == 0) begin
          chk("unexp_valid", 32'(valid), 0);
        end else begin
          e = sb.pop_front();
          if (e.chk) begin
            chk("count", 32'(count), e.cnt);
            chk("too_slow", 32'(too_slow), 32'(e.slow));
            chk("too_fast", 32'(too_fast), 32'(e.fast));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("fault", 32'(fault_sticky), 32'(e.flt));
          end
          if (e.gap != 0) chk("gap", cyc - last_v, e.gap);
        end
        last_v = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    resetb      = 1'b0;
    enable      = 1'b0;
    window_len  = 16'd99;
    lo_limit    = 12'd9;
    hi_limit    = 12'd11;
    fault_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs();
    @(posedge clk);
    #1 resetb = 1'b1;

    // Nominal period, back-to-back windows
    push(1, 10, 0, 0, 0, 0, 0);
    push(1, 10, 0, 0, 0, 0, 100);
    push(1, 10, 0, 0, 0, 0, 100);
    start_en();
    wait_first("lat_first");
    chk("busy_meas", 32'(busy), 1);
    drain(400);

    // Slow clock, then recovery with sticky fault held
    @(posedge clk); #1 per = 20;
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, 5, 1, 0, 0, 1, 100);
    push(1, 5, 1, 0, 0, 1, 100);
    drain(400);
    @(posedge clk); #1 per = 10;
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, 10, 0, 0, 0, 1, 100);
    push(1, 10, 0, 0, 0, 1, 100);
    drain(400);
    @(posedge clk); #1 fault_clear = 1'b1;
    @(posedge clk); #1 fault_clear = 1'b0;
    @(negedge clk);
    chk("fault_clr", 32'(fault_sticky), 0);
    push(1, 10, 0, 0, 0, 0, 100);
    drain(200);

    // Saturation over a long fast window
    @(posedge clk); #1;
    window_len = 16'd9999;
    per        = 2;
    hi_limit   = 12'd4000;
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, 4095, 0, 1, 1, 1, 10000);
    drain(10500);

    // Disable: results hold, then clear fault and re-enable
    @(posedge clk); #1;
    enable     = 1'b0;
    window_len = 16'd99;
    per        = 10;
    hi_limit   = 12'd11;
    repeat (3) @(negedge clk);
    chk("dis_busy", 32'(busy), 0);
    chk("dis_count", 32'(count), 4095);
    chk("dis_ovf", 32'(overflow), 1);
    @(posedge clk); #1 fault_clear = 1'b1;
    @(posedge clk); #1 fault_clear = 1'b0;
    @(negedge clk);
    chk("dis_fault_clr", 32'(fault_sticky), 0);
    push(1, 10, 0, 0, 0, 0, 0);
    start_en();
    wait_first("lat_reen1");
    drain(200);

    // Drop enable at cycle 50 of a window
    repeat (50) @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop_busy", 32'(busy), 0);
    repeat (150) @(negedge clk);
    chk("drop_count", 32'(count), 10);
    push(1, 10, 0, 0, 0, 0, 0);
    push(1, 10, 0, 0, 0, 0, 100);
    start_en();
    wait_first("lat_reen2");
    drain(300);

    // Window length change mid-window
    @(posedge clk); #1;
    window_len = 16'd49;
    lo_limit   = 12'd4;
    push(1, 10, 0, 0, 0, 0, 100);
    push(1, 5, 0, 0, 0, 0, 50);
    push(1, 5, 0, 0, 0, 0, 50);
    drain(400);

    // Inverted limits with clear held: set wins on the result cycle
    @(posedge clk); #1;
    lo_limit    = 12'd20;
    hi_limit    = 12'd3;
    fault_clear = 1'b1;
    push(1, 5, 1, 1, 0, 1, 50);
    drain(200);
    @(posedge clk); #1 fault_clear = 1'b0;
    @(negedge clk);
    chk("clr_after_set", 32'(fault_sticky), 0);

    // Asynchronous reset mid-window, then resume
    repeat (20) @(posedge clk);
    #3 resetb = 1'b0;
    #1;
    chk_reset_outs();
    window_len = 16'd99;
    lo_limit   = 12'd9;
    hi_limit   = 12'd11;
    repeat (3) @(posedge clk);
    push(1, 10, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 resetb = 1'b1;
    t0 = cyc;
    wait_first("lat_rst");
    drain(200);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
